rgb_pwm_ctrl: RTL and testbench

Three-channel PWM controller for the RGB LED peripheral. It drives one shared prescaler and one shared W-bit up-counting PWM timebase, and compares three per-channel duty values against that timebase to produce led_r, led_g and led_b. A valid/ready configuration port accepts new colours. New colours take effect only on a PWM period boundary, so every period is glitch-free. The block sits between the AXI register slice (configuration side) and the LED pins.

---
 rtl/rgb_pwm_ctrl.sv | 139 +++++++++++++
 tb/tb_rgb_pwm_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : rgb_pwm_ctrl                                                   |
// | Brief    : 3-channel RGB PWM with shared prescaler, period-aligned updates|
// |            Optional macro RGB_PWM_GAMMA_EN squares duties on load.        |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module rgb_pwm_ctrl #(
  parameter int W          = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale_div,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [W-1:0]          cfg_r,
  input  logic [W-1:0]          cfg_g,
  input  logic [W-1:0]          cfg_b,
  output logic                  led_r,
  output logic                  led_g,
  output logic                  led_b,
  output logic                  period_done
);

  localparam logic [W-1:0]          c_CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0]          c_PWM_ONE = W'(1);
  localparam logic [PRESCALE_W-1:0] c_PRE_ONE = PRESCALE_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic [W-1:0]          r_pwm_cnt;
  logic [W-1:0]          r_duty_r, r_duty_g, r_duty_b;
  logic [W-1:0]          r_pend_r, r_pend_g, r_pend_b;
  logic                  r_pend_full;
  logic                  r_wrap;

  logic w_tick;
  logic w_boundary;
  logic w_accept;

  assign w_tick     = (r_pre_cnt >= prescale_div);
  assign w_boundary = w_tick && (r_pwm_cnt == c_CNT_MAX);
  assign w_accept   = cfg_valid && !r_pend_full;
  assign cfg_ready  = !r_pend_full;

  function automatic logic [W-1:0] f_map(input logic [W-1:0] d);
`ifdef RGB_PWM_GAMMA_EN
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, d} * {{W{1'b0}}, d};
    return prod[2*W-1:W];
`else
    return d;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pre_cnt   <= '0;
      r_pwm_cnt   <= '0;
      r_duty_r    <= '0;
      r_duty_g    <= '0;
      r_duty_b    <= '0;
      r_pend_r    <= '0;
      r_pend_g    <= '0;
      r_pend_b    <= '0;
      r_pend_full <= 1'b0;
      r_wrap      <= 1'b0;
      led_r       <= 1'b0;
      led_g       <= 1'b0;
      led_b       <= 1'b0;
      period_done <= 1'b0;
    end else begin
      // Accept and load use opposite values of r_pend_full, so they never collide.
      if (w_accept) begin
        r_pend_r    <= cfg_r;
        r_pend_g    <= cfg_g;
        r_pend_b    <= cfg_b;
        r_pend_full <= 1'b1;
      end

      if (r_state == ST_IDLE) begin
        r_pre_cnt   <= '0;
        r_pwm_cnt   <= '0;
        r_wrap      <= 1'b0;
        led_r       <= 1'b0;
        led_g       <= 1'b0;
        led_b       <= 1'b0;
        period_done <= 1'b0;
        if (r_pend_full) begin
          r_duty_r    <= f_map(r_pend_r);
          r_duty_g    <= f_map(r_pend_g);
          r_duty_b    <= f_map(r_pend_b);
          r_pend_full <= 1'b0;
        end
        if (enable) begin
          r_state <= ST_RUN;
        end
      end else if (!enable) begin
        r_state     <= ST_IDLE;
        r_pre_cnt   <= '0;
        r_pwm_cnt   <= '0;
        r_wrap      <= 1'b0;
        led_r       <= 1'b0;
        led_g       <= 1'b0;
        led_b       <= 1'b0;
        period_done <= 1'b0;
      end else begin
        led_r       <= (r_pwm_cnt < r_duty_r);
        led_g       <= (r_pwm_cnt < r_duty_g);
        led_b       <= (r_pwm_cnt < r_duty_b);
        // Delayed by one so the pulse lines up with the first new-duty output.
        r_wrap      <= w_boundary;
        period_done <= r_wrap;
        if (w_tick) begin
          r_pre_cnt <= '0;
          r_pwm_cnt <= r_pwm_cnt + c_PWM_ONE;
        end else begin
          r_pre_cnt <= r_pre_cnt + c_PRE_ONE;
        end
        if (w_boundary && r_pend_full) begin
          r_duty_r    <= f_map(r_pend_r);
          r_duty_g    <= f_map(r_pend_g);
          r_duty_b    <= f_map(r_pend_b);
          r_pend_full <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_rgb_pwm_ctrl                                                |
// | Brief    : Self-checking bench for rgb_pwm_ctrl (W=8), per-period counts. |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module tb_rgb_pwm_ctrl;
  localparam int W  = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] prescale_div = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [W-1:0]  cfg_r = '0, cfg_g = '0, cfg_b = '0;
  logic          led_r, led_g, led_b, period_done;

  int total = 0;
  int bad   = 0;

  rgb_pwm_ctrl #(.W(W), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .prescale_div(prescale_div),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_r(cfg_r), .cfg_g(cfg_g), .cfg_b(cfg_b),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .period_done(period_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int div;
    int r, g, b;
    int exp_r, exp_g, exp_b, exp_len;
  } vec_t;

  vec_t vecs[5];

  // Effective duty after the optional squaring map on load.
  function automatic int emap(input int d);
`ifdef RGB_PWM_GAMMA_EN
    return (d * d) / 256;
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_pd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = period_done;
    end
    if (!ok) check("pd_timeout", 0, 1);
  endtask

  // Starts on a period_done cycle, ends on the next one.
  task automatic count_period(output int len, output int hr, output int hg, output int hb);
    len = 0; hr = 0; hg = 0; hb = 0;
    do begin
      len++;
      hr += int'(led_r);
      hg += int'(led_g);
      hb += int'(led_b);
      @(negedge clk);
    end while (!period_done && len < 5000);
  endtask

  task automatic measure(output int len, output int hr, output int hg, output int hb);
    bit ok;
    wait_pd(ok);
    count_period(len, hr, hg, hb);
  endtask

  task automatic offer(input int r, input int g, input int b);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      if (cfg_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) check("ready_timeout", 0, 1);
    cfg_r = W'(r); cfg_g = W'(g); cfg_b = W'(b);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic load_idle(input int r, input int g, input int b);
    enable = 1'b0;
    @(negedge clk);
    offer(r, g, b);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int len, hr, hg, hb, pdat, j, div, off;
    int nr, ng, nb, rr, rg, rb;
    bit ok;

    vecs[0] = '{0,   4,   8,   0, 0, 0, 0, 0};
    vecs[1] = '{2, 255,   0,   1, 0, 0, 0, 0};
    vecs[2] = '{1, 128, 200,  64, 0, 0, 0, 0};
    vecs[3] = '{0, 255, 255, 255, 0, 0, 0, 0};
    vecs[4] = '{3,  17,   1, 254, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      vecs[i].exp_r   = emap(vecs[i].r) * (vecs[i].div + 1);
      vecs[i].exp_g   = emap(vecs[i].g) * (vecs[i].div + 1);
      vecs[i].exp_b   = emap(vecs[i].b) * (vecs[i].div + 1);
      vecs[i].exp_len = 256 * (vecs[i].div + 1);
    end

    repeat (3) @(negedge clk);
    check("rst_ready", int'(cfg_ready), 1);
    check("rst_led_r", int'(led_r), 0);
    check("rst_led_g", int'(led_g), 0);
    check("rst_led_b", int'(led_b), 0);
    check("rst_pd", int'(period_done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      load_idle(vecs[i].r, vecs[i].g, vecs[i].b);
      prescale_div = PW'(vecs[i].div);
      enable = 1'b1;
      measure(len, hr, hg, hb);
      check($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
      check($sformatf("vec%0d_r", i), hr, vecs[i].exp_r);
      check($sformatf("vec%0d_g", i), hg, vecs[i].exp_g);
      check($sformatf("vec%0d_b", i), hb, vecs[i].exp_b);
      enable = 1'b0;
      @(negedge clk);
    end

    // Mid-period update waits for the boundary; a second offer stalls.
    prescale_div = '0;
    load_idle(100, 0, 0);
    enable = 1'b1;
    measure(len, hr, hg, hb);
    check("upd_old", hr, emap(100));
    repeat (50) @(negedge clk);
    offer(200, 0, 0);
    check("ready_drop", int'(cfg_ready), 0);
    cfg_r = W'(50);
    cfg_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("ready_stall", int'(cfg_ready), 0);
    cfg_valid = 1'b0;
    wait_pd(ok);
    check("ready_back", int'(cfg_ready), 1);
    count_period(len, hr, hg, hb);
    check("upd_new", hr, emap(200));

    // Transfer on the boundary edge is held for one more period.
    repeat (254) @(negedge clk);
    check("bnd_ready_pre", int'(cfg_ready), 1);
    cfg_r = W'(2);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("bnd_accept", int'(cfg_ready), 0);
    @(negedge clk);
    check("bnd_pd_time", int'(period_done), 1);
    count_period(len, hr, hg, hb);
    check("bnd_old", hr, emap(200));
    count_period(len, hr, hg, hb);
    check("bnd_new", hr, emap(2));

    // Disable mid-period with a pending colour.
    load_idle(250, 250, 250);
    enable = 1'b1;
    wait_pd(ok);
    repeat (5) @(negedge clk);
    check("pre_dis_led", int'(led_r), 1);
    offer(60, 0, 0);
    enable = 1'b0;
    @(negedge clk);
    check("dis_leds", int'(led_r) + int'(led_g) + int'(led_b), 0);
    check("dis_pd", int'(period_done), 0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    pdat = 0; hr = 0; j = 0;
    while (pdat == 0 && j < 2000) begin
      j++;
      @(negedge clk);
      if (period_done) pdat = j;
      else hr += int'(led_r);
      if (j == 2) check("rise", int'(led_r), int'(emap(60) != 0));
    end
    check("first_pd", pdat, 258);
    check("idle_applied", hr, emap(60));

    // Asynchronous reset mid-period.
    offer(220, 0, 0);
    check("pre_rst_ready", int'(cfg_ready), 0);
    check("pre_rst_led", int'(led_r), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_leds", int'(led_r) + int'(led_g) + int'(led_b), 0);
    check("arst_ready", int'(cfg_ready), 1);
    check("arst_pd", int'(period_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    measure(len, hr, hg, hb);
    check("arst_len", len, 256);
    check("arst_duty", hr + hg + hb, 0);

    // Randomized: load in IDLE, then a mid-period update in RUN.
    for (int it = 0; it < 8; it++) begin
      div = int'($urandom_range(0, 3));
      rr = int'($urandom_range(0, 255));
      rg = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      load_idle(rr, rg, rb);
      prescale_div = PW'(div);
      enable = 1'b1;
      measure(len, hr, hg, hb);
      check($sformatf("rnd%0d_len", it), len, 256 * (div + 1));
      check($sformatf("rnd%0d_r", it), hr, emap(rr) * (div + 1));
      check($sformatf("rnd%0d_g", it), hg, emap(rg) * (div + 1));
      check($sformatf("rnd%0d_b", it), hb, emap(rb) * (div + 1));
      nr = int'($urandom_range(0, 255));
      ng = int'($urandom_range(0, 255));
      nb = int'($urandom_range(0, 255));
      off = int'($urandom_range(1, 256 * (div + 1) - 5));
      repeat (off) @(negedge clk);
      offer(nr, ng, nb);
      measure(len, hr, hg, hb);
      check($sformatf("rnd%0d_nr", it), hr, emap(nr) * (div + 1));
      check($sformatf("rnd%0d_ng", it), hg, emap(ng) * (div + 1));
      check($sformatf("rnd%0d_nb", it), hb, emap(nb) * (div + 1));
      enable = 1'b0;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
